fp_mul_norm_round: RTL and testbench
====================================

// Module: fp_mul_norm_round
// PURPOSE
//  Back end of the single-precision FP multiplier. Consumes the sign, the raw biased-exponent sum and the
//  48-bit significand product from the Wallace-tree/exponent-add stage. Normalizes, applies IEEE-754
//  round-to-nearest-even, handles overflow/underflow/specials and packs a 32-bit result.
//  Two-stage valid/ready pipeline: full throughput, backpressure-safe.
// PARAMETERS
//  EXP_W   8    exponent field width
//  MAN_W   23   stored fraction width; product width PROD_W = 2*(MAN_W+1) = 48
//  BIAS    127  exponent bias
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       upstream has a product
//  in_ready   out  1       block accepts this cycle
//  in_sign    in   1       sign_a ^ sign_b
//  in_esum    in   9       ea + eb, biased, unsigned (0..510)
//  in_prod    in   48      {1,fa} * {1,fb}
//  in_cls     in   3       {nan, inf, zero}, precomputed upstream; nan covers NaN operand and inf*0
//  out_valid  out  1       result available
//  out_ready  in   1       downstream accepts
//  out_result out  32      {sign, exp[7:0], frac[22:0]}
//  out_flags  out  3       {overflow, underflow, inexact}
// BEHAVIOUR
//  Reset (clk edge with reset=1): s1_valid=0, s2_valid=0; out_valid=0, out_result=0, out_flags=0.
//  Reset beats everything: in-flight data is discarded, no output produced for it.
//  Handshake:
//   - Transfer on in_valid&in_ready / out_valid&out_ready.
//   - in_ready = !s1_valid | (!s2_valid | out_ready). Stage 2 loads when !s2_valid | out_ready.
//   - Stall: while out_valid & !out_ready, out_result/out_flags hold stable; stage 1 holds if full.
//   - Order preserved; latency 2 clk from accept to out_valid when not stalled.
//  Stage 1, normalize (registered):
//   - prod[47]=1: man=prod[46:24], g=prod[23], st=|prod[22:0], e=esum-BIAS+1
//   - else:       man=prod[45:23], g=prod[22], st=|prod[21:0], e=esum-BIAS
//   - e is an 11-bit signed value.
//  Stage 2, round/pack (registered):
//   - rup = g & (st | man[0]). man+rup; carry out of 23 bits -> man=0, e=e+1.
//   - inexact = g|st.
//   - e >= 255 -> +/-inf (exp=FF, frac=0), overflow=1, inexact=1.
//   - e <= 0 -> flush to signed zero (no subnormals), underflow=1, inexact=1.
//   - Specials override, priority nan > inf > zero, all flags 0:
//     nan -> 32'h7FC00000 (sign ignored); inf -> {s,FF,0}; zero -> {s,00,0}.
//  Simultaneous in/out transfers in the same cycle are legal and lose nothing.
// STRUCTURE
//  fp_pkg: EXP_W, MAN_W, BIAS, QNAN=32'h7FC00000, EXP_MAX=8'hFF, flag bit indices.
//  One sub-module: fp_rne_round (combinational man/g/st/e -> packed value + flags), instanced in stage 2.
//  Pipeline regs and handshake stay in this module.
// TESTING
//  1. esum=255, prod=48'h6000_0000_0000, cls=0, sign=0 -> 2 clk later 32'h40400000 (1.5*2.0), flags 0.
//  2. esum=254, prod=48'h9000_0000_0000 (1.5*1.5, shift path) -> 32'h40100000, flags 0.
//  3. RNE: esum=254, prod=48'h4000_0040_0000 -> 32'h3F800000, inexact=1 (tie, even);
//     prod=48'h4000_00C0_0000 -> 32'h3F800002, inexact=1.
//  4. Mantissa carry: esum=254, prod=48'h7FFF_FFC0_0000 -> 32'h40000000. Overflow: esum=400 -> 32'h7F800000,
//     flags 3'b101. Underflow: esum=100, sign=1 -> 32'h80000000, flags 3'b011.
//  5. Specials: cls=3'b111 -> 32'h7FC00000; cls=3'b010, sign=1 -> 32'hFF800000; cls=3'b001 -> 32'h00000000.
//  6. Backpressure/reset: out_ready=0 + 3 back-to-back inputs -> 2 accepted, in_ready=0, out stable;
//     out_ready=1 -> results in order. Reset pulse with both stages full -> out_valid=0 next clk, no stale output.

Source files
------------

// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants, types and helpers for the single-precision multiplier
// back end (normalize / round / pack).
//   EXP_W, MAN_W, BIAS   : IEEE-754 single-precision field widths and bias
//   PROD_W               : width of the raw significand product {1,fa}*{1,fb}
//   E_W                  : signed working exponent width (enough for -127..385)
//   QNAN, EXP_MAX        : canonical quiet NaN and the all-ones exponent
//   FLAG_*, CLS_*        : bit positions inside the flag and class vectors
// ---------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int BIAS   = 127;
  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  localparam int E_W    = EXP_W + 3;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;

  // Working exponent thresholds: at or above E_OVF the value is not
  // representable, at or below E_UNF it would need a subnormal.
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(255);
  localparam logic signed [E_W-1:0] E_UNF  = E_W'(0);
  localparam logic signed [E_W-1:0] BIAS_S = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);

  // Bit positions inside out_flags = {overflow, underflow, inexact}
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  // Bit positions inside in_cls = {nan, inf, zero}
  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  // What kind of word the packer has to produce
  typedef enum logic [2:0] {
    RES_NORMAL,
    RES_OVERFLOW,
    RES_UNDERFLOW,
    RES_NAN,
    RES_INF,
    RES_ZERO
  } res_kind_e;

  // Contents of the stage-1 register: everything the rounder needs
  typedef struct packed {
    logic                  sign;
    logic [2:0]            cls;
    logic [MAN_W-1:0]      man;
    logic                  g;
    logic                  st;
    logic signed [E_W-1:0] e;
  } norm_t;

  // Normalize the raw product. The product of two significands in [1,2)
  // lies in [1,4), so the leading one is at bit 47 or bit 46; the hidden
  // bit is dropped and the exponent is unbiased once (the sum carries the
  // bias twice) plus one if the product was >= 2.
  function automatic norm_t normalize(input logic              sign,
                                      input logic [EXP_W:0]    esum,
                                      input logic [PROD_W-1:0] prod,
                                      input logic [2:0]        cls);
    norm_t                 n;
    logic signed [E_W-1:0] esum_s;
    esum_s = $signed({{(E_W-EXP_W-1){1'b0}}, esum});
    n.sign = sign;
    n.cls  = cls;
    if (prod[PROD_W-1]) begin
      n.man = prod[PROD_W-2 -: MAN_W];
      n.g   = prod[PROD_W-2-MAN_W];
      n.st  = |prod[PROD_W-3-MAN_W:0];
      n.e   = esum_s - BIAS_S + E_ONE;
    end else begin
      n.man = prod[PROD_W-3 -: MAN_W];
      n.g   = prod[PROD_W-3-MAN_W];
      n.st  = |prod[PROD_W-4-MAN_W:0];
      n.e   = esum_s - BIAS_S;
    end
    return n;
  endfunction

  // Specials win over range problems, nan > inf > zero.
  function automatic res_kind_e classify(input logic [2:0] cls,
                                         input logic       ovf,
                                         input logic       unf);
    res_kind_e k;
    if (cls[CLS_NAN])       k = RES_NAN;
    else if (cls[CLS_INF])  k = RES_INF;
    else if (cls[CLS_ZERO]) k = RES_ZERO;
    else if (ovf)           k = RES_OVERFLOW;
    else if (unf)           k = RES_UNDERFLOW;
    else                    k = RES_NORMAL;
    return k;
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// ---------------------------------------------------------------------------
// fp_rne_round
// Combinational round-to-nearest-even and packing of a normalized value.
// Ports:
//   sign    in   result sign
//   cls     in   {nan, inf, zero} special-operand class
//   man     in   23-bit fraction before rounding
//   g, st   in   guard bit and sticky bit below the fraction
//   e       in   signed unbiased-then-rebiased exponent (11 bits)
//   result  out  packed {sign, exp, frac}
//   flags   out  {overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_rne_round
  import fp_pkg::*;
(
  input  logic                  sign,
  input  logic [2:0]            cls,
  input  logic [MAN_W-1:0]      man,
  input  logic                  g,
  input  logic                  st,
  input  logic signed [E_W-1:0] e,
  output logic [WORD_W-1:0]     result,
  output logic [2:0]            flags
);

  logic                  rup;
  logic [MAN_W:0]        man_sum;
  logic [MAN_W-1:0]      man_rnd;
  logic signed [E_W-1:0] e_rnd;
  logic                  inexact;
  logic                  ovf;
  logic                  unf;
  res_kind_e             kind;

  // Round half to even: bump only when above half, or exactly half with an
  // odd fraction. A carry out of the fraction means 1.111..1 became 10.0,
  // so the fraction wraps to zero and the exponent grows by one.
  always_comb begin
    rup     = g & (st | man[0]);
    man_sum = {1'b0, man} + {{MAN_W{1'b0}}, rup};
    man_rnd = man_sum[MAN_W] ? '0 : man_sum[MAN_W-1:0];
    e_rnd   = e + $signed({{(E_W-1){1'b0}}, man_sum[MAN_W]});
    inexact = g | st;
    ovf     = (e_rnd >= E_OVF);
    unf     = (e_rnd <= E_UNF);
  end

  always_comb begin
    kind = classify(cls, ovf, unf);
  end

  // Pack according to the result kind. Specials carry no flags; range
  // failures always lose information, so they also raise inexact.
  always_comb begin
    result = '0;
    flags  = '0;
    case (kind)
      RES_NAN: begin
        result = QNAN;
      end
      RES_INF: begin
        result = {sign, EXP_MAX, {MAN_W{1'b0}}};
      end
      RES_ZERO: begin
        result = {sign, {(WORD_W-1){1'b0}}};
      end
      RES_OVERFLOW: begin
        result          = {sign, EXP_MAX, {MAN_W{1'b0}}};
        flags[FLAG_OVF] = 1'b1;
        flags[FLAG_INX] = 1'b1;
      end
      RES_UNDERFLOW: begin
        result          = {sign, {(WORD_W-1){1'b0}}};
        flags[FLAG_UNF] = 1'b1;
        flags[FLAG_INX] = 1'b1;
      end
      default: begin
        result          = {sign, e_rnd[EXP_W-1:0], man_rnd};
        flags[FLAG_INX] = inexact;
      end
    endcase
  end

endmodule

// File: rtl/fp_mul_norm_round.sv
// ---------------------------------------------------------------------------
// fp_mul_norm_round
// Back end of the single-precision multiplier: normalize (stage 1), then
// round/pack (stage 2), as a two-stage valid/ready pipeline with full
// throughput and safe backpressure.
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   upstream handshake
//   in_sign               sign_a ^ sign_b
//   in_esum               ea + eb, biased (0..510)
//   in_prod               48-bit significand product {1,fa}*{1,fb}
//   in_cls                {nan, inf, zero} precomputed upstream
//   out_valid / out_ready downstream handshake
//   out_result            packed IEEE-754 single {sign, exp, frac}
//   out_flags             {overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_mul_norm_round
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W:0]    in_esum,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [2:0]        in_cls,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_result,
  output logic [2:0]        out_flags
);

  norm_t             s1_d;
  norm_t             s1_q;
  logic              s1_valid;
  logic              s2_load;
  logic [WORD_W-1:0] rnd_result;
  logic [2:0]        rnd_flags;

  // Stage 2 (the output register) can take new data when it is empty or
  // its contents leave this cycle; stage 1 can then always move forward,
  // so the input side is only blocked when both stages are stuck.
  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;

  always_comb begin
    s1_d = normalize(in_sign, in_esum, in_prod, in_cls);
  end

  // Stage 1 register: holds its contents whenever it cannot pass them on.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  fp_rne_round u_round (
    .sign   (s1_q.sign),
    .cls    (s1_q.cls),
    .man    (s1_q.man),
    .g      (s1_q.g),
    .st     (s1_q.st),
    .e      (s1_q.e),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  // Stage 2 register drives the outputs directly, so a stalled result
  // stays stable until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= rnd_result;
        out_flags  <= rnd_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// ---------------------------------------------------------------------------
// tb_fp_mul_norm_round
// Self-checking bench for fp_mul_norm_round: directed vectors for the
// normalize, rounding, range and special cases, handshake/backpressure and
// reset scenarios, and a randomized stream scored against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_fp_mul_norm_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [8:0]  in_esum = '0;
  logic [47:0] in_prod = '0;
  logic [2:0]  in_cls = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        s;
    logic [8:0]  es;
    logic [47:0] p;
    logic [2:0]  c;
    logic [31:0] er;
    logic [2:0]  ef;
  } vec_t;

  fp_mul_norm_round dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_esum    (in_esum),
    .in_prod    (in_prod),
    .in_cls     (in_cls),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Safety net so a wedged handshake can never hang the run
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: scales the product down to 24 significant bits,
  // rounds by comparing the discarded remainder with one half, then
  // applies the exponent range and special-value rules.
  function automatic void model_fp(input logic s, input logic [8:0] es,
                                   input logic [47:0] p, input logic [2:0] c,
                                   output logic [31:0] res, output logic [2:0] fl);
    longint unsigned pv, mant, rem, half, one;
    int              shift, e;
    fl = 3'b000;
    if (c[2]) res = QNAN;
    else if (c[1]) res = {s, 8'hFF, 23'h0};
    else if (c[0]) res = {s, 31'h0};
    else begin
      one   = 1;
      pv    = {16'h0, p};
      shift = p[47] ? 24 : 23;
      mant  = pv >> shift;
      rem   = pv & ((one << shift) - 1);
      half  = one << (shift - 1);
      e     = int'(es) - 127 + (p[47] ? 1 : 0);
      if (rem > half || (rem == half && mant[0] == 1'b1)) mant = mant + 1;
      if (mant == (one << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0};
        fl  = 3'b101;
      end else if (e <= 0) begin
        res = {s, 31'h0};
        fl  = 3'b011;
      end else begin
        res = {s, 8'(e), mant[22:0]};
        fl  = {2'b00, rem != 0};
      end
    end
  endfunction

  // Present one operand set on the input port (called just after a negedge)
  task automatic applyStimulus(input logic s, input logic [8:0] es,
                               input logic [47:0] p, input logic [2:0] c);
    in_valid = 1'b1;
    in_sign  = s;
    in_esum  = es;
    in_prod  = p;
    in_cls   = c;
  endtask

  // Push one operand set through an empty pipeline and capture the result
  // together with the number of negedges from acceptance to out_valid.
  task automatic transact(input logic s, input logic [8:0] es,
                          input logic [47:0] p, input logic [2:0] c,
                          output logic got, output logic [31:0] res,
                          output logic [2:0] fl, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    applyStimulus(s, es, p, c);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    res = '0;
    fl  = '0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (out_valid) begin
        got = 1'b1;
        res = out_result;
        fl  = out_flags;
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_result !== 32'h0 || out_flags !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %h/%b expected 00000000/000", out_result, out_flags);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_normalize();
    vec_t        v[$];
    logic        got;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b0, 9'd255, 48'h6000_0000_0000, 3'b000, 32'h4040_0000, 3'b000});
    v.push_back('{1'b0, 9'd254, 48'h9000_0000_0000, 3'b000, 32'h4010_0000, 3'b000});
    foreach (v[i]) begin
      transact(v[i].s, v[i].es, v[i].p, v[i].c, got, r, f, lat);
      checks++;
      if (!got || r !== v[i].er || f !== v[i].ef) begin
        failures++;
        $display("[TB] FAIL normalize_%0d: got %h/%b expected %h/%b", i, r, f, v[i].er, v[i].ef);
      end
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("[TB] FAIL latency_%0d: got %0d expected 2", i, lat);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t        v[$];
    logic        got;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b0, 9'd254, 48'h4000_0040_0000, 3'b000, 32'h3F80_0000, 3'b001});
    v.push_back('{1'b0, 9'd254, 48'h4000_00C0_0000, 3'b000, 32'h3F80_0002, 3'b001});
    foreach (v[i]) begin
      transact(v[i].s, v[i].es, v[i].p, v[i].c, got, r, f, lat);
      checks++;
      if (!got || r !== v[i].er || f !== v[i].ef) begin
        failures++;
        $display("[TB] FAIL rne_%0d: got %h/%b expected %h/%b", i, r, f, v[i].er, v[i].ef);
      end
    end
  endtask

  task automatic test_range();
    vec_t        v[$];
    logic        got;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b0, 9'd254, 48'h7FFF_FFC0_0000, 3'b000, 32'h4000_0000, 3'b001});
    v.push_back('{1'b0, 9'd400, 48'h4000_0000_0000, 3'b000, 32'h7F80_0000, 3'b101});
    v.push_back('{1'b1, 9'd100, 48'h4000_0000_0000, 3'b000, 32'h8000_0000, 3'b011});
    foreach (v[i]) begin
      transact(v[i].s, v[i].es, v[i].p, v[i].c, got, r, f, lat);
      checks++;
      if (!got || r !== v[i].er || f !== v[i].ef) begin
        failures++;
        $display("[TB] FAIL range_%0d: got %h/%b expected %h/%b", i, r, f, v[i].er, v[i].ef);
      end
    end
  endtask

  task automatic test_specials();
    vec_t        v[$];
    logic        got;
    logic [31:0] r;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b1, 9'd254, 48'h9000_0000_0000, 3'b111, 32'h7FC0_0000, 3'b000});
    v.push_back('{1'b1, 9'd400, 48'h4000_0000_0000, 3'b010, 32'hFF80_0000, 3'b000});
    v.push_back('{1'b0, 9'd100, 48'h7FFF_FFC0_0000, 3'b001, 32'h0000_0000, 3'b000});
    foreach (v[i]) begin
      transact(v[i].s, v[i].es, v[i].p, v[i].c, got, r, f, lat);
      checks++;
      if (!got || r !== v[i].er || f !== v[i].ef) begin
        failures++;
        $display("[TB] FAIL special_%0d: got %h/%b expected %h/%b", i, r, f, v[i].er, v[i].ef);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(1'b0, 9'd255, 48'h6000_0000_0000, 3'b000);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_accept_a: got %b expected 1", in_ready);
    end
    @(negedge clk);
    applyStimulus(1'b0, 9'd254, 48'h9000_0000_0000, 3'b000);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_accept_b: got %b expected 1", in_ready);
    end
    @(negedge clk);
    applyStimulus(1'b0, 9'd254, 48'h4000_00C0_0000, 3'b000);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_block_c: got %b expected 0", in_ready);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h4040_0000 || out_flags !== 3'b000) begin
        failures++;
        $display("[TB] FAIL bp_hold: got rdy=%b vld=%b %h/%b expected rdy=0 vld=1 40400000/000",
                 in_ready, out_valid, out_result, out_flags);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h4010_0000 || out_flags !== 3'b000) begin
      failures++;
      $display("[TB] FAIL bp_order_b: got vld=%b %h/%b expected vld=1 40100000/000", out_valid, out_result, out_flags);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h3F80_0002 || out_flags !== 3'b001) begin
      failures++;
      $display("[TB] FAIL bp_order_c: got vld=%b %h/%b expected vld=1 3f800002/001", out_valid, out_result, out_flags);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(1'b0, 9'd255, 48'h6000_0000_0000, 3'b000);
    @(negedge clk);
    applyStimulus(1'b1, 9'd254, 48'h9000_0000_0000, 3'b000);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_full: got vld=%b rdy=%b expected vld=1 rdy=0", out_valid, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b000 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL flush_reset: got vld=%b %h/%b rdy=%b expected vld=0 00000000/000 rdy=1",
               out_valid, out_result, out_flags, in_ready);
    end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL flush_stale: got %b expected 0", out_valid);
      end
    end
  endtask

  // Random stream with random input gaps and random downstream stalls.
  // Inputs change only at negedges; transfers are decided from the
  // settled handshake signals just after that.
  task automatic test_random(input int n);
    logic [34:0] expq[$];
    logic [34:0] exp_item;
    logic [31:0] m_res;
    logic [2:0]  m_fl;
    logic [23:0] a, b;
    logic [47:0] p;
    logic [8:0]  es;
    logic [2:0]  c;
    logic        s;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    logic [2:0]  prev_fl = '0;
    int          sent = 0;
    int          recv = 0;
    int          cycles = 0;
    in_valid = 1'b0;
    while ((sent < n || expq.size() > 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== prev_res || out_flags !== prev_fl) begin
          failures++;
          $display("[TB] FAIL rand_stall_hold: got vld=%b %h/%b expected vld=1 %h/%b",
                   out_valid, out_result, out_flags, prev_res, prev_fl);
        end
      end
      if (sent < n && $urandom_range(0, 3) != 0) begin
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        p = {24'h0, a} * {24'h0, b};
        case ($urandom_range(0, 3))
          0: es = 9'($urandom_range(0, 510));
          1: es = 9'($urandom_range(120, 132));
          2: es = 9'($urandom_range(375, 384));
          default: es = 9'($urandom_range(150, 350));
        endcase
        c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        s = 1'($urandom);
        applyStimulus(s, es, p, c);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_extra: got %h expected no output", out_result);
        end else begin
          exp_item = expq.pop_front();
          if (out_result !== exp_item[34:3] || out_flags !== exp_item[2:0]) begin
            failures++;
            $display("[TB] FAIL rand_result_%0d: got %h/%b expected %h/%b",
                     recv, out_result, out_flags, exp_item[34:3], exp_item[2:0]);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        model_fp(in_sign, in_esum, in_prod, in_cls, m_res, m_fl);
        expq.push_back({m_res, m_fl});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      prev_fl    = out_flags;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sent != n || expq.size() != 0 || recv != n) begin
      failures++;
      $display("[TB] FAIL rand_complete: got sent=%0d recv=%0d expected %0d each", sent, recv, n);
    end
  endtask

  initial begin
    test_reset();
    test_normalize();
    test_rounding();
    test_range();
    test_specials();
    test_backpressure();
    test_reset_flush();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
